// File: rtl/inv_kin_sampler.sv
// inv_kin_sampler
//   Handshake wrapper around the combinational/iterative inv_kin block.
//   A request (x, y) is accepted over valid/ready, registered onto kin_x/kin_y,
//   held for SETTLE_CYCLES clock edges, and then {x, y, theta1, theta2} is
//   captured into a small output FIFO that a valid/ready consumer drains.
//   Data is passed through untouched (Q17.15 by default).
//
// Optional feature macro: INV_KIN_SAMPLER_STABLE_CHECK_EN
//   When defined, each captured entry carries an "unstable" bit that is set
//   when theta changed between the edge before capture and the capture edge,
//   and err_unstable latches any such capture until rst.
//   When undefined, out_unstable and err_unstable are tied to 0.
//
// Ports:
//   clock, rst                 rising-edge clock, async active-high reset
//   in_valid/in_ready          request handshake, in_x/in_y request operands
//   kin_x/kin_y                registered operands driven into inv_kin
//   kin_theta1/kin_theta2      results coming back from inv_kin
//   out_valid/out_ready        FIFO head handshake
//   out_x/out_y/out_theta1/out_theta2/out_unstable   FIFO head fields
//   err_unstable               sticky unstable-capture flag
//   busy                       high while operands are settling

module inv_kin_sampler #(
    parameter int BIT_WIDTH     = 32,
    parameter int FRACTIONS     = 15,
    parameter int SETTLE_CYCLES = 500,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_x,
    input  logic [BIT_WIDTH-1:0] in_y,
    output logic [BIT_WIDTH-1:0] kin_x,
    output logic [BIT_WIDTH-1:0] kin_y,
    input  logic [BIT_WIDTH-1:0] kin_theta1,
    input  logic [BIT_WIDTH-1:0] kin_theta2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_x,
    output logic [BIT_WIDTH-1:0] out_y,
    output logic [BIT_WIDTH-1:0] out_theta1,
    output logic [BIT_WIDTH-1:0] out_theta2,
    output logic                 out_unstable,
    output logic                 err_unstable,
    output logic                 busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    // Elaboration-time parameter sanity checks.
    if (FRACTIONS < 0 || FRACTIONS >= BIT_WIDTH) begin : g_bad_fractions
        $error("inv_kin_sampler: FRACTIONS must be in 0..BIT_WIDTH-1");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535) begin : g_bad_settle
        $error("inv_kin_sampler: SETTLE_CYCLES must be in 1..65535");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("inv_kin_sampler: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t          state, state_nxt;
    logic [15:0]     counter;
    logic            live;
    logic            accept, push, pop;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;

    logic [BIT_WIDTH-1:0] mem_x  [FIFO_DEPTH];
    logic [BIT_WIDTH-1:0] mem_y  [FIFO_DEPTH];
    logic [BIT_WIDTH-1:0] mem_t1 [FIFO_DEPTH];
    logic [BIT_WIDTH-1:0] mem_t2 [FIFO_DEPTH];

    // State register.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake decode. in_ready is held low until the first
    // edge after reset so nothing is accepted while reset is asserted.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = live && (count < CW'(FIFO_DEPTH));
                accept   = in_valid && in_ready;
                if (accept) state_nxt = SETTLE;
            end
            SETTLE: begin
                busy = 1'b1;
                if (counter == 16'd0) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pop = (count != '0) && out_ready;

    // Operand registers and settle counter; operands only move on accept.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            live    <= 1'b0;
            counter <= 16'd0;
            kin_x   <= '0;
            kin_y   <= '0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                kin_x   <= in_x;
                kin_y   <= in_y;
                counter <= 16'(SETTLE_CYCLES - 1);
            end else if (state == SETTLE && counter != 16'd0) begin
                counter <= counter - 16'd1;
            end
        end
    end

    // Output FIFO: power-of-two depth so pointers wrap on their own; push
    // cannot overflow because acceptance already reserved the slot.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_x[i]  <= '0;
                mem_y[i]  <= '0;
                mem_t1[i] <= '0;
                mem_t2[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_x[wr_ptr]  <= kin_x;
                mem_y[wr_ptr]  <= kin_y;
                mem_t1[wr_ptr] <= kin_theta1;
                mem_t2[wr_ptr] <= kin_theta2;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_valid  = (count != '0);
    assign out_x      = mem_x[rd_ptr];
    assign out_y      = mem_y[rd_ptr];
    assign out_theta1 = mem_t1[rd_ptr];
    assign out_theta2 = mem_t2[rd_ptr];

`ifdef INV_KIN_SAMPLER_STABLE_CHECK_EN
    logic [2*BIT_WIDTH-1:0] prev_theta;
    logic                   unstable_now;
    logic                   mem_u [FIFO_DEPTH];
    logic                   err_q;

    // With a single settle cycle the previous sample belongs to the old
    // operands, so the comparison would be meaningless; it is forced off.
    assign unstable_now = (SETTLE_CYCLES > 1) &&
                          ({kin_theta1, kin_theta2} != prev_theta);

    // Theta history, per-entry unstable bits and the sticky error flag.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            prev_theta <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_u[i] <= 1'b0;
        end else begin
            prev_theta <= {kin_theta1, kin_theta2};
            if (push) begin
                mem_u[wr_ptr] <= unstable_now;
                if (unstable_now) err_q <= 1'b1;
            end
        end
    end

    assign out_unstable = mem_u[rd_ptr];
    assign err_unstable = err_q;
`else
    assign out_unstable = 1'b0;
    assign err_unstable = 1'b0;
`endif

endmodule

// File: doc/inv_kin_sampler.md
Name: inv_kin_sampler

Overview:
- Wrapper stage placed around inv_kin, which is purely combinational/iterative and has no valid strobe.
- Accepts (x, y) requests over a valid/ready handshake and drives them onto inv_kin's x/y inputs, holding them stable for SETTLE_CYCLES.
- Then samples theta1/theta2 and pushes {x, y, theta1, theta2} into a small output FIFO drained by a valid/ready consumer.
- Replaces fixed-delay waiting in benches and system integration; all values are Q17.15.

Parameters:
BIT_WIDTH, 32, data width of x, y, theta1, theta2 (Q(BIT_WIDTH-FRACTIONS).FRACTIONS)
FRACTIONS, 15, fractional bits; informational only, no arithmetic depends on it
SETTLE_CYCLES, 500, cycles operands are held before theta is sampled; legal range 1..65535
FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2

Ports:
clock  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready at rising edge
in_x  in  BIT_WIDTH  request x
in_y  in  BIT_WIDTH  request y
kin_x  out  BIT_WIDTH  registered x to inv_kin
kin_y  out  BIT_WIDTH  registered y to inv_kin
kin_theta1  in  BIT_WIDTH  theta1 from inv_kin
kin_theta2  in  BIT_WIDTH  theta2 from inv_kin
out_valid  out  1  FIFO head valid (FIFO not empty)
out_ready  in  1  consumer pop when out_valid && out_ready
out_x, out_y, out_theta1, out_theta2  out  BIT_WIDTH each  FIFO head fields
out_unstable  out  1  FIFO head unstable flag (see Optional Feature)
err_unstable  out  1  sticky unstable error
busy  out  1  high in SETTLE state

Behaviour:
- Reset (asynchronous, immediate):
  - Outputs: in_ready=0, kin_x=0, kin_y=0, out_valid=0, all out_* fields 0, busy=0, err_unstable=0.
  - State: FSM=IDLE, counter=0, FIFO empty; any in-flight request is discarded.
  - in_ready may rise on the first clock edge after rst deasserts.
- FSM has two states, IDLE and SETTLE.
  - IDLE: in_ready = (fifo_count < FIFO_DEPTH), combinational from registered state. On accept: kin_x<=in_x, kin_y<=in_y, counter<=SETTLE_CYCLES-1, state<=SETTLE.
  - SETTLE: in_ready=0, busy=1. Counter decrements each edge. At the edge where counter==0: push {kin_x, kin_y, kin_theta1, kin_theta2} sampled at that edge, state<=IDLE.
- Latency:
  - Request accepted at edge E0; theta sampled at edge E0+SETTLE_CYCLES.
  - out_valid is visible after that edge when the FIFO was empty.
  - Next request can be accepted at edge E0+SETTLE_CYCLES+1 at the earliest.
- Operand hold:
  - kin_x/kin_y change only on accept and hold their last value in IDLE.
  - in_x/in_y changes while not accepting have no effect.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)-bit pointers wrapping naturally, plus a count of log2(FIFO_DEPTH)+1 bits.
  - Push never fails: acceptance is gated on count<FIFO_DEPTH and only one request is in flight.
  - Simultaneous push and pop: count unchanged, both pointers advance; legal also when count==FIFO_DEPTH-1 or count==FIFO_DEPTH (the pop frees the slot).
  - Pop when empty is ignored.
  - out_* show the head entry; they hold their value when empty (don't-care to consumer).
- Backpressure: out_ready low indefinitely → FIFO fills to FIFO_DEPTH, then in_ready stays 0 in IDLE.
- Arithmetic: none on data; pass-through only, no sign handling.

Optional Feature:
- INV_KIN_SAMPLER_STABLE_CHECK_EN defined:
  - A register holds {kin_theta1, kin_theta2} from the previous edge.
  - At the capture edge, the pushed entry's unstable bit = (current theta != previous theta); for SETTLE_CYCLES==1 the bit is always 0.
  - err_unstable sets when any entry with unstable=1 is pushed; it is cleared only by rst.
- Not defined:
  - No history register.
  - out_unstable and err_unstable are constant 0; ports remain present.

Test Plan:
- Single request, SETTLE_CYCLES=8, x=0x0000C000 (1.5), y=0x00008000 (1.0), stub theta1=0x00001234, theta2=0x00005678 → in_ready low for 8 cycles; out_valid rises after edge E0+8; out_* = {0xC000, 0x8000, 0x1234, 0x5678}.
- Backpressure, FIFO_DEPTH=4, out_ready=0, 6 back-to-back requests → exactly 4 accepted; in_ready stays 0 with count=4. Raise out_ready for 1 cycle → 5th request accepted; entries pop in order.
- Simultaneous push/pop at count=3: pop coincides with capture edge → count stays 3; pointers wrap across the index 3→0 boundary with order preserved.
- Reset mid-SETTLE: assert rst at counter=3 → busy, out_valid, kin_x drop to 0 immediately; no entry appears after release.
- INV_KIN_SAMPLER_STABLE_CHECK_EN: stub theta changes 0x100→0x101 one cycle before capture → out_unstable=1, err_unstable=1 and stays 1 until rst. Without the macro → both 0.
- SETTLE_CYCLES=1 edge case: accept at E0 → capture at E0+1, next accept at E0+2 earliest.
